// File: rtl/sr_drive_encoder.sv
// Converts level requests into timed set/reset pulses for a downstream SR latch.
// Latency: pulse starts the cycle after accept, done PULSE_W+1 cycles after accept.
// Backpressure: req_ready low while pulsing and during the post-pulse gap.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   req_valid, req_level  level request (held by requester until accepted)
//   req_ready             high only when idle; accept = req_valid & req_ready
//   s, r                  set / reset drive, one-hot or both low
//   q_model               tracked level of the downstream latch
//   done, skip            one-cycle strobes: pulse finished / no pulse needed
module sr_drive_encoder #(
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 1,
  parameter int CNT_W   = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic req_valid,
  input  logic req_level,
  output logic req_ready,
  output logic s,
  output logic r,
  output logic q_model,
  output logic done,
  output logic skip
);

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W - 1);
  // GAP_LD is only loaded when GAP_W > 0; guard keeps it well-defined otherwise.
  localparam logic [CNT_W-1:0] GAP_LD   = (GAP_W > 0) ? CNT_W'(GAP_W - 1) : '0;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             s_nxt, r_nxt, q_nxt, done_nxt, skip_nxt, ready_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      s         <= 1'b0;
      r         <= 1'b0;
      q_model   <= 1'b0;
      done      <= 1'b0;
      skip      <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      s         <= s_nxt;
      r         <= r_nxt;
      q_model   <= q_nxt;
      done      <= done_nxt;
      skip      <= skip_nxt;
      req_ready <= ready_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    s_nxt     = s;
    r_nxt     = r;
    q_nxt     = q_model;
    done_nxt  = 1'b0;
    skip_nxt  = 1'b0;
    ready_nxt = req_ready;

    case (state)
      IDLE: begin
        ready_nxt = 1'b1;
        // req_ready is always 1 in IDLE, so req_valid alone means accept.
        if (req_valid) begin
          if (req_level == q_model) begin
            skip_nxt = 1'b1;
          end else begin
            state_nxt = PULSE;
            cnt_nxt   = PULSE_LD;
            s_nxt     = req_level;
            r_nxt     = ~req_level;
            ready_nxt = 1'b0;
          end
        end
      end

      PULSE: begin
        if (cnt == '0) begin
          s_nxt    = 1'b0;
          r_nxt    = 1'b0;
          // The asserted drive tells which level the latch now holds.
          q_nxt    = s;
          done_nxt = 1'b1;
          if (GAP_W == 0) begin
            state_nxt = IDLE;
            ready_nxt = 1'b1;
          end else begin
            state_nxt = GAP;
            cnt_nxt   = GAP_LD;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end

      GAP: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
          ready_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end

      default: begin
        state_nxt = IDLE;
        s_nxt     = 1'b0;
        r_nxt     = 1'b0;
        ready_nxt = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_sr_drive_encoder.sv
// Bench for sr_drive_encoder: two instances (PULSE_W=2/GAP_W=1 and PULSE_W=3/GAP_W=0),
// a timeline-based reference model compared every cycle, directed literal
// checks for the documented sequences, then randomized requests and resets.
module tb_sr_drive_encoder;

  localparam int PA = 2, GA = 1;
  localparam int PB = 3, GB = 0;

  function automatic int pw(int i);
    return (i == 0) ? PA : PB;
  endfunction
  function automatic int gw(int i);
    return (i == 0) ? GA : GB;
  endfunction

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] rv, rl, rdy, so, ro, qo, dn, sk;

  always #5 clk = ~clk;

  sr_drive_encoder #(.PULSE_W(PA), .GAP_W(GA), .CNT_W(4)) dut_a (
    .clk(clk), .reset(reset), .req_valid(rv[0]), .req_level(rl[0]),
    .req_ready(rdy[0]), .s(so[0]), .r(ro[0]), .q_model(qo[0]),
    .done(dn[0]), .skip(sk[0]));

  sr_drive_encoder #(.PULSE_W(PB), .GAP_W(GB), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .req_valid(rv[1]), .req_level(rl[1]),
    .req_ready(rdy[1]), .s(so[1]), .r(ro[1]), .q_model(qo[1]),
    .done(dn[1]), .skip(sk[1]));

  // Reference model state: an accepted pulse is described by its accept edge
  // number and level; everything else follows from the cycle offset.
  bit m_busy[2], m_lvl[2], m_q[2], m_done[2], m_skip[2], m_acc[2], lat[2];
  int m_t0[2];
  int cyc = 0;
  bit m_rst = 0, started = 0;
  int n_cmp = 0, n_bad = 0;

  task automatic chk(string name, logic act, logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: advances on every rising edge using the inputs presented at it.
  initial forever begin
    int c;
    @(posedge clk);
    cyc++;
    m_rst = reset;
    if (reset) started = 1;
    for (int i = 0; i < 2; i++) begin
      m_done[i] = 0;
      m_skip[i] = 0;
      m_acc[i]  = 0;
      if (reset) begin
        m_busy[i] = 0;
        m_q[i]    = 0;
      end else if (!m_busy[i]) begin
        if (rv[i]) begin
          m_acc[i] = 1;
          if (rl[i] == m_q[i]) m_skip[i] = 1;
          else begin
            m_busy[i] = 1;
            m_t0[i]   = cyc;
            m_lvl[i]  = rl[i];
          end
        end
      end else begin
        c = cyc - m_t0[i] + 1;           // cycle number now starting (accept edge = 0)
        if (c == pw(i) + 1) begin
          m_q[i]    = m_lvl[i];
          m_done[i] = 1;
        end
        if (c == pw(i) + gw(i) + 1) m_busy[i] = 0;
      end
    end
  end

  // Per-cycle compare on the falling edge, plus a reference SR latch driven by s/r.
  initial forever begin
    int  c;
    bit  es, er;
    @(negedge clk);
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        c  = cyc - m_t0[i] + 1;
        es = m_busy[i] && (c <= pw(i)) && m_lvl[i];
        er = m_busy[i] && (c <= pw(i)) && !m_lvl[i];
        chk($sformatf("s[%0d]", i), so[i], es);
        chk($sformatf("r[%0d]", i), ro[i], er);
        chk($sformatf("q_model[%0d]", i), qo[i], m_q[i]);
        chk($sformatf("done[%0d]", i), dn[i], m_done[i]);
        chk($sformatf("skip[%0d]", i), sk[i], m_skip[i]);
        chk($sformatf("req_ready[%0d]", i), rdy[i], !m_busy[i]);
        chk($sformatf("s_and_r[%0d]", i), so[i] & ro[i], 1'b0);
        chk($sformatf("done_and_skip[%0d]", i), dn[i] & sk[i], 1'b0);
        if (m_rst) lat[i] = 0;
        if (so[i] === 1'b1) lat[i] = 1;
        else if (ro[i] === 1'b1) lat[i] = 0;
        if (rdy[i] === 1'b1) chk($sformatf("latch_vs_q[%0d]", i), qo[i], lat[i]);
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL timeout: got no finish want finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int rcnt, nacc, ndone, last;
    reset = 1; rv = '0; rl = '0;
    step; step;
    reset = 0;
    @(negedge clk);
    chk("rst_rdy", rdy[0], 1'b1); chk("rst_q", qo[0], 1'b0); chk("rst_s", so[0], 1'b0);

    // Set pulse on A: accept at edge 0.
    rv[0] = 1; rl[0] = 1;
    step; rv[0] = 0;
    @(negedge clk);
    chk("c1_s", so[0], 1'b1); chk("c1_r", ro[0], 1'b0); chk("c1_rdy", rdy[0], 1'b0);
    step; @(negedge clk);
    chk("c2_s", so[0], 1'b1); chk("c2_rdy", rdy[0], 1'b0); chk("c2_done", dn[0], 1'b0);
    step; @(negedge clk);
    chk("c3_s", so[0], 1'b0); chk("c3_q", qo[0], 1'b1); chk("c3_done", dn[0], 1'b1);
    chk("c3_rdy", rdy[0], 1'b0);
    step; @(negedge clk);
    chk("c4_rdy", rdy[0], 1'b1); chk("c4_done", dn[0], 1'b0);

    // Same-level requests on consecutive edges.
    rv[0] = 1; rl[0] = 1;
    for (int k = 0; k < 3; k++) begin
      step; @(negedge clk);
      chk("skip_strobe", sk[0], 1'b1); chk("skip_rdy", rdy[0], 1'b1); chk("skip_s", so[0], 1'b0);
    end
    rv[0] = 0;
    step; @(negedge clk);
    chk("skip_end", sk[0], 1'b0);

    // Clear pulse with request held through the busy window.
    rv[0] = 1; rl[0] = 0;
    step;
    rcnt = 0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      rcnt += int'(ro[0]);
      chk("held_not_ready", rdy[0], 1'b0);
      chk("held_no_skip", sk[0], 1'b0);
      if (k == 3) begin
        chk("clr_q", qo[0], 1'b0);
        rv[0] = 0;
      end
    end
    chk_int("r_pulse_len", rcnt, PA);
    step; @(negedge clk);
    chk("clr_rdy_back", rdy[0], 1'b1);

    // Alternating requests on B (GAP_W=0), held continuously.
    rv[1] = 1; rl[1] = 1; nacc = 0; ndone = 0; last = 0;
    for (int k = 0; k < 40 && nacc < 3; k++) begin
      step;
      ndone += int'(dn[1]);
      if (m_acc[1]) begin
        if (nacc > 0) chk_int("alt_accept_gap", cyc - last, PB + 1);
        last = cyc;
        nacc++;
        if (nacc == 3) rv[1] = 0;
        else rl[1] = ~rl[1];
      end
    end
    chk_int("alt_accepts", nacc, 3);
    repeat (PB + 1) begin
      step;
      ndone += int'(dn[1]);
    end
    chk_int("alt_done_count", ndone, 3);

    // Reset in cycle 1 of a set pulse on A.
    rv[0] = 1; rl[0] = 1;
    step; rv[0] = 0;
    chk("abort_c1_s", so[0], 1'b1);
    reset = 1;
    step; reset = 0;
    chk("abort_s", so[0], 1'b0); chk("abort_q", qo[0], 1'b0);
    chk("abort_done", dn[0], 1'b0); chk("abort_rdy", rdy[0], 1'b1);
    repeat (4) begin
      step;
      chk("abort_no_done", dn[0], 1'b0);
    end

    // Randomized requests and occasional resets.
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (m_acc[i] || !rv[i]) begin
          rv[i] = ($urandom_range(0, 2) != 0);
          rl[i] = 1'($urandom_range(0, 1));
        end
      end
      reset = ($urandom_range(0, 199) == 0);
      step;
    end
    reset = 0; rv = '0;
    step; step;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
